// File: rtl/core_mem_store_pkg.sv
// Shared encodings for the store unit: funct3 values, fault causes and FSM states.
// The macros are the encodings other pipeline files refer to; the localparams wrap them for typed use.
`ifndef CORE_MEM_STORE_DEFINES
`define CORE_MEM_STORE_DEFINES
`define STORE_SB             3'b000
`define STORE_SH             3'b001
`define STORE_SW             3'b010
`define STORE_FAULT_NONE     2'b00
`define STORE_FAULT_MISALIGN 2'b01
`define STORE_FAULT_ILLEGAL  2'b10
`define STORE_FAULT_TIMEOUT  2'b11
`endif

package core_mem_store_pkg;

    localparam logic [2:0] F3_SB = `STORE_SB;
    localparam logic [2:0] F3_SH = `STORE_SH;
    localparam logic [2:0] F3_SW = `STORE_SW;

    localparam logic [1:0] FAULT_NONE     = `STORE_FAULT_NONE;
    localparam logic [1:0] FAULT_MISALIGN = `STORE_FAULT_MISALIGN;
    localparam logic [1:0] FAULT_ILLEGAL  = `STORE_FAULT_ILLEGAL;
    localparam logic [1:0] FAULT_TIMEOUT  = `STORE_FAULT_TIMEOUT;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

endpackage

// File: rtl/core_mem_store_if.sv
// Request and data-bus signals of the store unit; slave is the unit itself, master its environment.
interface core_mem_store_if;

    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [2:0]  i_funct3;
    logic        o_bus_req;
    logic [29:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_wsel;
    logic        i_bus_ack;
    logic        o_done;
    logic        o_fault;
    logic [1:0]  o_fault_cause;

    modport slave (
        input  i_valid, i_addr, i_data, i_funct3, i_bus_ack,
        output o_ready, o_bus_req, o_bus_addr, o_bus_wdata, o_bus_wsel,
        output o_done, o_fault, o_fault_cause
    );

    modport master (
        output i_valid, i_addr, i_data, i_funct3, i_bus_ack,
        input  o_ready, o_bus_req, o_bus_addr, o_bus_wdata, o_bus_wsel,
        input  o_done, o_fault, o_fault_cause
    );

endinterface

// File: rtl/core_store_align.sv
// Combinational lane replication, byte-select generation and fault classification for stores.
module core_store_align
    import core_mem_store_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    output logic [31:0] wdata,
    output logic [3:0]  wsel,
    output logic        misalign,
    output logic        illegal
);

    logic [31:0] sb_wdata;
    logic [31:0] sh_wdata;
    logic [3:0]  sb_wsel;
    logic [3:0]  sh_wsel;

    // Each lane carries the low byte (SB) or the matching half of the low halfword (SH).
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign sb_wdata[8*gi +: 8] = data[7:0];
        assign sh_wdata[8*gi +: 8] = data[8*(gi%2) +: 8];
        assign sb_wsel[gi]         = (addr == 2'(gi));
        assign sh_wsel[gi]         = (addr[1] == 1'(gi/2));
    end

    always_comb begin
        wdata    = data;
        wsel     = 4'b0000;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (funct3)
            F3_SB: begin
                wdata = sb_wdata;
                wsel  = sb_wsel;
            end
            F3_SH: begin
                wdata    = sh_wdata;
                wsel     = sh_wsel;
                misalign = addr[0];
            end
            F3_SW: begin
                wsel     = 4'b1111;
                misalign = |addr;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/core_mem_store.sv
// Store unit: accepts SB/SH/SW, issues one word-addressed bus write at a time with ack timeout,
// and reports completion or faults as single-cycle pulses.
module core_mem_store
    import core_mem_store_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input logic             i_clk,
    input logic             i_reset,
    core_mem_store_if.slave mem
);

    localparam int               CNT_W    = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             bus_req_reg;
    logic [29:0]      addr_reg;
    logic [31:0]      wdata_reg;
    logic [3:0]       wsel_reg;
    logic             done_reg;
    logic             fault_reg;
    logic [1:0]       cause_reg;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_wsel;
    logic        misalign;
    logic        illegal;
    logic        accept;

    core_store_align u_align (
        .addr     (mem.i_addr[1:0]),
        .data     (mem.i_data),
        .funct3   (mem.i_funct3),
        .wdata    (lane_wdata),
        .wsel     (lane_wsel),
        .misalign (misalign),
        .illegal  (illegal)
    );

    assign mem.o_ready = (state_reg == ST_IDLE) && !i_reset;
    assign accept      = mem.i_valid && mem.o_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bus_req_reg <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wsel_reg    <= '0;
            done_reg    <= 1'b0;
            fault_reg   <= 1'b0;
            cause_reg   <= FAULT_NONE;
        end else begin
            done_reg  <= 1'b0;
            fault_reg <= 1'b0;
            cause_reg <= FAULT_NONE;
            case (state_reg)
                ST_IDLE: begin
                    // Illegal funct3 is checked first so it masks any misalignment.
                    if (accept) begin
                        if (illegal) begin
                            fault_reg <= 1'b1;
                            cause_reg <= FAULT_ILLEGAL;
                        end else if (misalign) begin
                            fault_reg <= 1'b1;
                            cause_reg <= FAULT_MISALIGN;
                        end else begin
                            addr_reg    <= mem.i_addr[31:2];
                            wdata_reg   <= lane_wdata;
                            wsel_reg    <= lane_wsel;
                            bus_req_reg <= 1'b1;
                            cnt_reg     <= '0;
                            state_reg   <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    // Ack is tested before the timeout so a last-cycle ack still completes cleanly.
                    if (mem.i_bus_ack) begin
                        bus_req_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else if (cnt_reg == CNT_LAST) begin
                        bus_req_reg <= 1'b0;
                        fault_reg   <= 1'b1;
                        cause_reg   <= FAULT_TIMEOUT;
                        state_reg   <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mem.o_bus_req     = bus_req_reg;
    assign mem.o_bus_addr    = addr_reg;
    assign mem.o_bus_wdata   = wdata_reg;
    assign mem.o_bus_wsel    = wsel_reg;
    assign mem.o_done        = done_reg;
    assign mem.o_fault       = fault_reg;
    assign mem.o_fault_cause = cause_reg;

endmodule

// File: tb/tb_core_mem_store.sv
// Scoreboard bench for core_mem_store: dut0 uses the default ack timeout, dut1 a timeout of 4.
module tb_core_mem_store;

    typedef struct {
        bit         is_fault;
        logic [1:0] cause;
        int         due;
    } evt_t;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wsel;
        int          len;
        int          start;
    } bus_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        int          ack_wait;   // cycles of req before ack; -1 means never ack
        logic [1:0]  fcause;     // nonzero: request is rejected with this cause
        logic [31:0] wdata;
        logic [3:0]  wsel;
        int          len;        // expected number of req-high cycles
    } vec_t;

    logic clk;
    logic srst;
    int   cyc_n = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 0;

    logic [1:0]        valid_s;
    logic [1:0]        ack_s;
    logic [1:0][31:0]  addr_s;
    logic [1:0][31:0]  data_s;
    logic [1:0][2:0]   f3_s;
    logic [1:0]        ready_s;
    logic [1:0]        req_s;
    logic [1:0]        done_s;
    logic [1:0]        fault_s;
    logic [1:0][1:0]   cause_s;
    logic [1:0][29:0]  baddr_s;
    logic [1:0][31:0]  wdata_s;
    logic [1:0][3:0]   wsel_s;

    evt_t evt_q[2][$];
    bus_t bus_q[2][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", name, d, cyc_n, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        core_mem_store_if mif ();

        assign mif.i_valid   = valid_s[gi];
        assign mif.i_addr    = addr_s[gi];
        assign mif.i_data    = data_s[gi];
        assign mif.i_funct3  = f3_s[gi];
        assign mif.i_bus_ack = ack_s[gi];
        assign ready_s[gi]   = mif.o_ready;
        assign req_s[gi]     = mif.o_bus_req;
        assign done_s[gi]    = mif.o_done;
        assign fault_s[gi]   = mif.o_fault;
        assign cause_s[gi]   = mif.o_fault_cause;
        assign baddr_s[gi]   = mif.o_bus_addr;
        assign wdata_s[gi]   = mif.o_bus_wdata;
        assign wsel_s[gi]    = mif.o_bus_wsel;

        core_mem_store #(.ACK_TIMEOUT(gi == 0 ? 255 : 4)) u_dut (
            .i_clk   (clk),
            .i_reset (srst),
            .mem     (mif)
        );

        evt_t e;
        bus_t cur;
        bit   in_req = 0;
        int   run = 0;

        always @(negedge clk) begin
            if (mon_en) begin
                if (done_s[gi] || fault_s[gi]) begin
                    chk("done_fault_excl", gi, 32'(done_s[gi] & fault_s[gi]), 32'd0);
                    if (evt_q[gi].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_evt dut%0d cycle %0d: got done=%0b fault=%0b cause=%0d, expected no pulse",
                                 gi, cyc_n, done_s[gi], fault_s[gi], cause_s[gi]);
                    end else begin
                        e = evt_q[gi].pop_front();
                        chk("evt_is_fault", gi, 32'(fault_s[gi]), 32'(e.is_fault));
                        chk("evt_cause", gi, 32'(cause_s[gi]), e.is_fault ? 32'(e.cause) : 32'd0);
                        chk("evt_cycle", gi, 32'(cyc_n), 32'(e.due));
                    end
                end else begin
                    chk("cause_idle", gi, 32'(cause_s[gi]), 32'd0);
                end

                if (req_s[gi]) begin
                    if (!in_req) begin
                        if (bus_q[gi].size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL unexpected_req dut%0d cycle %0d: got bus_req=1, expected 0", gi, cyc_n);
                            cur = '{'0, '0, '0, -1, cyc_n};
                        end else begin
                            cur = bus_q[gi].pop_front();
                            chk("req_start_cycle", gi, 32'(cyc_n), 32'(cur.start));
                        end
                        in_req = 1;
                        run = 0;
                    end
                    run++;
                    chk("bus_addr", gi, 32'(baddr_s[gi]), 32'(cur.addr));
                    chk("bus_wdata", gi, wdata_s[gi], cur.wdata);
                    chk("bus_wsel", gi, 32'(wsel_s[gi]), 32'(cur.wsel));
                    chk("ready_in_bus", gi, 32'(ready_s[gi]), 32'd0);
                end else if (in_req) begin
                    in_req = 0;
                    chk("req_len", gi, 32'(run), 32'(cur.len));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int d, input vec_t v);
        int n;
        n = cyc_n;
        if (v.fcause != 2'b00) begin
            evt_q[d].push_back('{1'b1, v.fcause, n + 1});
        end else begin
            bus_q[d].push_back('{v.addr[31:2], v.wdata, v.wsel, v.len, n + 1});
            if (v.ack_wait >= 0) evt_q[d].push_back('{1'b0, 2'b00, n + 2 + v.ack_wait});
            else                 evt_q[d].push_back('{1'b1, 2'b11, n + 1 + v.len});
        end
        valid_s[d] = 1'b1;
        addr_s[d]  = v.addr;
        data_s[d]  = v.data;
        f3_s[d]    = v.f3;
        tick();
        valid_s[d] = 1'b0;
        if (v.fcause == 2'b00) begin
            if (v.ack_wait >= 0) begin
                repeat (v.ack_wait) tick();
                ack_s[d] = 1'b1;
                tick();
                ack_s[d] = 1'b0;
            end else begin
                repeat (v.len) tick();
            end
        end
    endtask

    vec_t vecs0[11] = '{
        '{32'h0000_1003, 32'h0000_00A5, 3'b000,  0, 2'b00, 32'hA5A5_A5A5, 4'b1000, 1},
        '{32'h0000_2002, 32'h1234_BEEF, 3'b001,  5, 2'b00, 32'hBEEF_BEEF, 4'b1100, 6},
        '{32'h0000_3001, 32'h0000_0000, 3'b010,  0, 2'b01, 32'h0,         4'b0000, 0},
        '{32'h0000_3001, 32'h0000_0000, 3'b011,  0, 2'b10, 32'h0,         4'b0000, 0},
        '{32'h0000_0004, 32'h0000_0000, 3'b111,  0, 2'b10, 32'h0,         4'b0000, 0},
        '{32'h0000_0005, 32'h0000_0000, 3'b001,  0, 2'b01, 32'h0,         4'b0000, 0},
        '{32'h0000_0001, 32'h1234_5678, 3'b000,  0, 2'b00, 32'h7878_7878, 4'b0010, 1},
        '{32'h0000_0002, 32'h0000_009C, 3'b000,  1, 2'b00, 32'h9C9C_9C9C, 4'b0100, 2},
        '{32'h0000_4000, 32'hCAFE_F00D, 3'b001,  0, 2'b00, 32'hF00D_F00D, 4'b0011, 1},
        '{32'h0000_0008, 32'hDEAD_BEEF, 3'b010,  2, 2'b00, 32'hDEAD_BEEF, 4'b1111, 3},
        '{32'h0000_3002, 32'h0000_0000, 3'b010,  0, 2'b01, 32'h0,         4'b0000, 0}
    };

    vec_t vecs1[3] = '{
        '{32'h0000_0010, 32'h55AA_55AA, 3'b010, -1, 2'b00, 32'h55AA_55AA, 4'b1111, 4},
        '{32'h0000_0010, 32'h55AA_55AA, 3'b010,  3, 2'b00, 32'h55AA_55AA, 4'b1111, 4},
        '{32'h0000_0012, 32'h0000_ABCD, 3'b001,  2, 2'b00, 32'hABCD_ABCD, 4'b1100, 3}
    };

    initial begin
        srst    = 1'b1;
        valid_s = '0;
        ack_s   = '0;
        addr_s  = '0;
        data_s  = '0;
        f3_s    = '0;
        repeat (3) tick();

        for (int d = 0; d < 2; d++) begin
            chk("rst_req", d, 32'(req_s[d]), 32'd0);
            chk("rst_done", d, 32'(done_s[d]), 32'd0);
            chk("rst_fault", d, 32'(fault_s[d]), 32'd0);
            chk("rst_cause", d, 32'(cause_s[d]), 32'd0);
            chk("rst_addr", d, 32'(baddr_s[d]), 32'd0);
            chk("rst_wdata", d, wdata_s[d], 32'd0);
            chk("rst_wsel", d, 32'(wsel_s[d]), 32'd0);
            chk("rst_ready_low", d, 32'(ready_s[d]), 32'd0);
        end
        srst = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) chk("ready_after_rst", d, 32'(ready_s[d]), 32'd1);
        mon_en = 1;

        foreach (vecs0[i]) run_vec(0, vecs0[i]);
        foreach (vecs1[i]) run_vec(1, vecs1[i]);

        // Reset while dut0 holds a request: req runs 3 cycles, then drops with no pulse.
        bus_q[0].push_back('{30'h10, 32'h1122_3344, 4'b1111, 3, cyc_n + 1});
        valid_s[0] = 1'b1;
        addr_s[0]  = 32'h0000_0040;
        data_s[0]  = 32'h1122_3344;
        f3_s[0]    = 3'b010;
        tick();
        valid_s[0] = 1'b0;
        tick();
        tick();
        srst = 1'b1;
        tick();
        chk("req_after_rst", 0, 32'(req_s[0]), 32'd0);
        chk("ready_in_rst", 0, 32'(ready_s[0]), 32'd0);
        srst = 1'b0;
        #1;
        chk("ready_after_midrst", 0, 32'(ready_s[0]), 32'd1);
        tick();

        // Stray ack while idle must not produce a done pulse.
        ack_s[0] = 1'b1;
        tick();
        tick();
        ack_s[0] = 1'b0;
        chk("stray_ack_done", 0, 32'(done_s[0]), 32'd0);
        tick();
        chk("stray_ack_req", 0, 32'(req_s[0]), 32'd0);

        // Accept still works after the stray ack.
        run_vec(0, '{32'h0000_0003, 32'h0000_00E1, 3'b000, 0, 2'b00, 32'hE1E1_E1E1, 4'b1000, 1});

        repeat (4) tick();
        for (int d = 0; d < 2; d++) begin
            chk("evt_q_drained", d, 32'(evt_q[d].size()), 32'd0);
            chk("bus_q_drained", d, 32'(bus_q[d].size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/core_mem_store.md
# core_mem_store

Store-side memory interface unit of the core pipeline. It accepts SB/SH/SW requests from the memory stage and replicates store data into byte lanes. It generates byte-lane selects and drives a single-outstanding word-addressed bus write with a req/ack handshake. Misaligned or illegal requests and bus timeouts are reported as one-cycle faults.

## Interface
- `ACK_TIMEOUT`, default 255: maximum cycles `o_bus_req` is held without `i_bus_ack` before abort; legal range 2..65535.

Ports:
- `i_clk`  in  1  core clock; all state on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  store request valid.
- `o_ready`  out  1  unit can accept; a request is accepted on `i_valid && o_ready`.
- `i_addr`  in  32  byte address (ALU result).
- `i_data`  in  32  store source (rs2).
- `i_funct3`  in  3  store width: 000 SB, 001 SH, 010 SW.
- `o_bus_req`  out  1  write request to data memory.
- `o_bus_addr`  out  30  word address, `i_addr[31:2]` of accepted request.
- `o_bus_wdata`  out  32  lane-replicated write data.
- `o_bus_wsel`  out  4  byte-lane write enables; bit n covers `wdata[8n+:8]`.
- `i_bus_ack`  in  1  write complete; honoured only while `o_bus_req`=1.
- `o_done`  out  1  one-cycle pulse: bus write completed.
- `o_fault`  out  1  one-cycle pulse: request rejected or aborted.
- `o_fault_cause`  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout; 00 when `o_fault`=0.

## Operation
- FSM states: IDLE, BUS.
- `o_ready` = (state==IDLE) && !`i_reset`.
- IDLE, accepted request, legal and aligned: register addr/wdata/wsel, go to BUS, clear timeout counter.
- IDLE, accepted request, faulty: stay IDLE, no bus activity, `o_fault` pulse with the cause on the next cycle.
- Fault priority: illegal funct3 (any value other than 000/001/010) over misalignment.
- Misaligned: SH with `addr[0]`=1; SW with `addr[1:0]`≠00. SB never misaligned.
- Lane rules:
  - SB: wdata = {4{data[7:0]}}, wsel = 0001 << addr[1:0].
  - SH: wdata = {2{data[15:0]}}, wsel = addr[1] ? 1100 : 0011.
  - SW: wdata = data, wsel = 1111.
- BUS: `o_bus_req`=1. Addr, wdata and wsel stay stable until exit.
  - On `i_bus_ack`: go to IDLE; `o_done` pulses next cycle.
  - Timeout: the counter increments each BUS cycle without ack. When it reaches `ACK_TIMEOUT`-1 with no ack, drop `o_bus_req`, go to IDLE, and pulse `o_fault` with cause 11 next cycle.
- Ack and timeout in the same cycle: ack wins, no fault.
- `i_bus_ack` while IDLE: ignored; no `o_done`.
- `o_done` and `o_fault` are mutually exclusive in any cycle.

## Timing
- Accept at cycle N: `o_bus_req`=1 from N+1.
- Ack sampled at cycle M: `o_bus_req`=0 and `o_done`=1 at M+1, `o_ready`=1 at M+1.
- Next acceptance is possible in M+1. Minimum 2 cycles per store (ack in N+1).
- Fault on acceptance at N: `o_fault` at N+1. `o_ready` stays 1, so back-to-back faulty requests give back-to-back fault pulses.
- Timeout: `o_bus_req` is high for exactly `ACK_TIMEOUT` cycles.
- Reset values: state IDLE; `o_bus_req`, `o_done`, `o_fault`=0; `o_fault_cause`=00; `o_bus_addr`, `o_bus_wdata`, `o_bus_wsel`=0; counter=0.
- Reset mid-BUS aborts the transaction silently: no fault, no done, and `o_bus_req`=0 the cycle after reset is sampled.

## Structure
- Add the following to `rv_defines.vh`:
  - store funct3 macros: `` `STORE_SB ``, `` `STORE_SH ``, `` `STORE_SW ``
  - fault-cause macros: `` `STORE_FAULT_NONE ``, `` `STORE_FAULT_MISALIGN ``, `` `STORE_FAULT_ILLEGAL ``, `` `STORE_FAULT_TIMEOUT ``
- One combinational sub-module, `core_store_align`:
  - inputs: addr[1:0], data, funct3
  - outputs: wdata, wsel, misalign, illegal
  - owns all lane and fault-classification logic; FSM, counter and handshake stay in `core_mem_store`.
- Counter width is $clog2(`ACK_TIMEOUT`).

## Test plan
- SB, addr=0x1003, data=0xA5, ack at N+1 → at N+1 bus_addr=0x400, wdata=0xA5A5A5A5, wsel=1000; `o_done` at N+2.
- SH, addr=0x2002, data=0x1234BEEF, ack delayed 5 cycles → wdata=0xBEEFBEEF and wsel=1100, both stable for the 6 req cycles; `o_ready`=0 throughout.
- SW, addr=0x3001 → no `o_bus_req`; `o_fault`=1 with cause 01 at N+1. funct3=011 at the same addr → cause 10 (illegal wins).
- `ACK_TIMEOUT`=4, SW addr=0x10, no ack → req high exactly 4 cycles, then `o_fault` with cause 11. Repeat with ack on the 4th cycle → `o_done` only, no fault.
- Reset asserted during BUS → next cycle req=0, no done or fault pulse, `o_ready`=1 after reset deasserts. Stray ack while IDLE → no `o_done`.
